cmd_arbiter: RTL

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/tpu_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/cmd_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared command-word layout for the TPU host interface: field offsets, the
// packed command struct and a helper that flags commands with an empty dimension.
package tpu_pkg;

   localparam int TPU_CMD_W = 64;
   localparam int DIM_W     = 8;
   localparam int ADDR_W    = 10;

   localparam int M_LSB = 0;
   localparam int K_LSB = 8;
   localparam int N_LSB = 16;
   localparam int A_LSB = 24;
   localparam int B_LSB = 34;
   localparam int C_LSB = 44;
   localparam int D_LSB = 54;

   localparam int DIMS_W = N_LSB + DIM_W;

   typedef struct packed {
      logic [ADDR_W-1:0] d_addr;
      logic [ADDR_W-1:0] c_addr;
      logic [ADDR_W-1:0] b_addr;
      logic [ADDR_W-1:0] a_addr;
      logic [DIM_W-1:0]  n;
      logic [DIM_W-1:0]  k;
      logic [DIM_W-1:0]  m;
   } cmd_t;

   // True when any of M, K or N is zero, i.e. the command describes no work.
   function automatic logic has_zero_dim(input logic [DIMS_W-1:0] dims);
      return (dims[M_LSB +: DIM_W] == 8'h00) ||
             (dims[K_LSB +: DIM_W] == 8'h00) ||
             (dims[N_LSB +: DIM_W] == 8'h00);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: the search starts at ptr and wraps modulo N;
// the first requesting index wins.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

   logic [IDX_W:0]   pos_s;
   logic [IDX_W-1:0] idx_s;
   logic             hit_s;
   logic             found_s;

   // Walk the requesters starting at ptr; ptr < N so one wrap subtraction suffices.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      pos_s     = '0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos_s     = {1'b0, ptr} + (IDX_W+1)'(k);
         idx_s     = (pos_s >= N_W) ? IDX_W'(pos_s - N_W) : IDX_W'(pos_s);
         hit_s     = req[idx_s] & ~found_s;
         grant[idx_s] = hit_s;
         grant_idx = hit_s ? idx_s : grant_idx;
         found_s   = found_s | req[idx_s];
      end
   end

endmodule

// File: rtl/cmd_arbiter.sv
// Host command arbiter: round-robin grant into a one-deep output register, with an
// in-order tag FIFO routing completion pulses back. Option: CMD_ARB_ZERO_DIM_FILTER_EN.
module cmd_arbiter
   import tpu_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CMD_WIDTH       = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]      req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              cmd_valid,
   output logic [CMD_WIDTH-1:0]              cmd_data,
   input  logic                              cmd_ready,
   input  logic                              done_irq,
   output logic [NUM_REQ-1:0]                req_done,
   output logic [$clog2(MAX_OUTSTANDING):0]  inflight,
   output logic                              busy,
   output logic                              err_spurious_done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]     rr_ptr_r;
   logic [NUM_REQ-1:0]   arb_grant_s;
   logic [IDX_W-1:0]     arb_idx_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic                 out_free_s;
   logic [CMD_WIDTH-1:0] sel_data_s;
   logic                 zero_dim_s;
   logic                 accept_s;
   logic                 fwd_s;
   logic                 drop_s;
   logic                 pop_s;
   logic [NUM_REQ-1:0]   pop_mask_s;
   logic [IDX_W-1:0]     head_tag_s;

   logic                 cmd_valid_r;
   logic [CMD_WIDTH-1:0] cmd_data_r;
   logic [CNT_W-1:0]     inflight_r;
   logic [NUM_REQ-1:0]   req_done_r;
   logic                 err_r;
   logic [IDX_W-1:0]     tag_mem_r [MAX_OUTSTANDING];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr_r),
      .grant     (arb_grant_s),
      .grant_idx (arb_idx_s)
   );

   // Grant only into a free output stage with FIFO room; inflight is the registered
   // value, so a completion in a full cycle opens the grant one cycle later.
   always_comb begin
      grant_s    = '0;
      out_free_s = !cmd_valid_r || cmd_ready;
      if (!rst && out_free_s && (inflight_r < MAX_CNT)) begin
         grant_s = arb_grant_s;
      end else begin
         grant_s = '0;
      end
   end

   // One-hot data mux of the granted requester's command slice.
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_data_s = sel_data_s |
                      (req_data[i*CMD_WIDTH +: CMD_WIDTH] & {CMD_WIDTH{grant_s[i]}});
      end
   end

`ifdef CMD_ARB_ZERO_DIM_FILTER_EN
   assign zero_dim_s = has_zero_dim(sel_data_s[DIMS_W-1:0]);
`else
   assign zero_dim_s = 1'b0;
`endif

   assign accept_s   = |grant_s;
   assign fwd_s      = accept_s & ~zero_dim_s;
   assign drop_s     = accept_s & zero_dim_s;
   assign pop_s      = done_irq && (inflight_r != '0);
   assign head_tag_s = tag_mem_r[rd_ptr_r];

   // Completion pulse goes to the requester whose tag sits at the FIFO head.
   always_comb begin
      pop_mask_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pop_mask_s[i] = pop_s && (head_tag_s == IDX_W'(i));
      end
   end

   // Output stage, tag pointers, outstanding count, RR pointer and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid_r <= 1'b0;
         cmd_data_r  <= '0;
         inflight_r  <= '0;
         req_done_r  <= '0;
         err_r       <= 1'b0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         rr_ptr_r    <= '0;
      end else begin
         if (fwd_s) begin
            cmd_valid_r <= 1'b1;
            cmd_data_r  <= sel_data_s;
         end else if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
         end

         req_done_r <= pop_mask_s | (drop_s ? grant_s : '0);

         case ({fwd_s, pop_s})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
         endcase

         if (fwd_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end

         if (accept_s) begin
            rr_ptr_r <= (arb_idx_s == LAST_IDX) ? '0 : arb_idx_s + IDX_W'(1);
         end

         if (done_irq && (inflight_r == '0)) begin
            err_r <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (fwd_s) begin
         tag_mem_r[wr_ptr_r] <= arb_idx_s;
      end
   end

   assign req_ready         = grant_s;
   assign cmd_valid         = cmd_valid_r;
   assign cmd_data          = cmd_data_r;
   assign inflight          = inflight_r;
   assign req_done          = req_done_r;
   assign err_spurious_done = err_r;
   assign busy              = !rst && ((inflight_r != '0) || cmd_valid_r);

endmodule
